// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

    // Scanner phases: parked, inter-digit blanking, digit lit.
    typedef enum logic [1:0] {
        OFF,
        DEAD,
        SHOW
    } scan_state_t;

    // All anodes released (active-low drive, so all ones is dark).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Digits on the module; index 0 is the rightmost.
    localparam int NUM_DIGITS = 4;

    // Index of the leftmost digit, where a frame ends.
    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    // Active-low one-hot anode pattern for digit idx.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Cycle counter for one digit slot. The count restarts at the end of every
// slot and is held at zero while the scanner is parked.
module disp_slot_timer #(
    parameter int TICK_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic dead_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    // Strobes decoded straight from the count; the owner qualifies them by state.
    assign dead_end = (cnt == CNT_W'(DEAD_CYCLES - 1));
    assign slot_end = (cnt == CNT_W'(TICK_DIV - 1));

    // Slot counter: zero while parked, otherwise wraps every TICK_DIV cycles.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode display scanner. Takes a snapshot of the digits
// once per frame, walks an active-low anode select across them with a short
// blanking gap between digits, and applies leading-zero blanking, per-digit
// blink and decimal-point drive.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_mask,
    input  logic [3:0] blink_mask,
    input  logic       lzb,
    output logic [3:0] an,
    output logic [3:0] mdigit,
    output logic       dp,
    output logic       frame_tick
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    scan_state_t state;
    logic [1:0]  idx;

    // Frame snapshot
    logic [NUM_DIGITS-1:0][3:0] snap_digit;
    logic [NUM_DIGITS-1:0]      snap_dp;
    logic [NUM_DIGITS-1:0]      snap_blink;
    logic                       snap_lzb;
    logic                       snap_phase;

    // Blink pacing
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    logic                  run;
    logic                  dead_end;
    logic                  slot_end;
    logic                  snap_take;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] digit_blank;

    disp_slot_timer #(
        .TICK_DIV    (TICK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .dead_end (dead_end),
        .slot_end (slot_end)
    );

    // The timer only counts while scanning; a dropped enable clears it at once.
    assign run = enable && (state != OFF);

    // A frame starts when scanning begins or when the last digit's slot ends;
    // a falling enable on that same edge suppresses it.
    assign snap_take = enable &&
                       ((state == OFF) ||
                        ((state == SHOW) && slot_end && (idx == LAST_IDX)));

    // Per-digit blanking from the snapshot: leading zeros ripple down from the
    // leftmost digit (digit 0 always stays lit), blink applies per mask bit.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lz_blank    = '0;
        lz_blank[3] = snap_lzb && (snap_digit[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (snap_digit[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (snap_digit[1] == 4'd0);
        digit_blank = lz_blank | (snap_blink & {NUM_DIGITS{snap_phase}});
    end

    // Snapshot and blink counter. The phase is captured before it toggles, so
    // one whole frame sees one phase and the first BLINK_FRAMES frames after
    // reset are lit.
    // NOTE: the snapshot registers are reset along with the control state so
    // the blanking decode never sees unknown digits after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_digit  <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lzb    <= 1'b0;
            snap_phase  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (snap_take) begin
            snap_digit <= {d3, d2, d1, d0};
            snap_dp    <= dp_mask;
            snap_blink <= blink_mask;
            snap_lzb   <= lzb;
            snap_phase <= blink_phase;
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // Scan FSM with registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= OFF;
            idx        <= 2'd0;
            an         <= AN_OFF;
            mdigit     <= 4'd0;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= snap_take;
            if (!enable) begin
                state <= OFF;
                idx   <= 2'd0;
                an    <= AN_OFF;
                dp    <= 1'b1;
            end else begin
                case (state)
                    OFF: begin
                        state <= DEAD;
                        idx   <= 2'd0;
                        an    <= AN_OFF;
                        dp    <= 1'b1;
                    end
                    DEAD: begin
                        if (dead_end) begin
                            state  <= SHOW;
                            mdigit <= snap_digit[idx];
                            if (digit_blank[idx]) begin
                                an <= AN_OFF;
                                dp <= 1'b1;
                            end else begin
                                an <= an_select(idx);
                                dp <= ~snap_dp[idx];
                            end
                        end
                    end
                    SHOW: begin
                        if (slot_end) begin
                            state <= DEAD;
                            idx   <= idx + 2'd1;
                            an    <= AN_OFF;
                            dp    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= OFF;
                        idx   <= 2'd0;
                        an    <= AN_OFF;
                        dp    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl. Stimulus queues one expected frame per
// snapshot; a negedge monitor aligns on FRAME_TICK and checks every cycle.
module tb_disp_scan_ctrl;

    localparam int TICK_DIV     = 8;
    localparam int DEAD_CYCLES  = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * TICK_DIV;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] dp_mask;
    logic [3:0] blink_mask;
    logic       lzb;
    logic [3:0] an;
    logic [3:0] mdigit;
    logic       dp;
    logic       frame_tick;

    disp_scan_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .an         (an),
        .mdigit     (mdigit),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected content of one frame; len = cycles the frame runs before
    // enable drops, gap = idle cycles expected before its FRAME_TICK (-1: any).
    typedef struct {
        logic [3:0][3:0] dig;
        logic [3:0]      shown;
        logic [3:0]      dpm;
        int              len;
        int              gap;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    int n_model  = 0;
    int prev_gap = -1;
    int pushed   = 0;

    // Monitor state
    bit         mon_en      = 1'b0;
    bit         in_frame    = 1'b0;
    int         k           = 0;
    int         idle        = 0;
    int         frames_seen = 0;
    frame_exp_t cur;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: which digits light for a frame, from the digit values,
    // the masks and the index of this snapshot since reset.
    function automatic frame_exp_t build_exp(input logic [15:0] dig, input logic [3:0] dpm,
                                             input logic [3:0] blm, input logic lz,
                                             input int n, input int len, input int gap);
        frame_exp_t e;
        int         h;
        logic       phase_on;
        h = -1;
        for (int i = 0; i < 4; i++)
            if (dig[4*i +: 4] != 4'd0) h = i;
        phase_on = ((n / BLINK_FRAMES) % 2) == 1;
        e.dig = dig;
        e.dpm = dpm;
        e.len = len;
        e.gap = gap;
        for (int s = 0; s < 4; s++)
            e.shown[s] = !((lz && (s > 0) && (s > h)) || (phase_on && blm[s]));
        return e;
    endfunction

    task automatic check_cycle(input frame_exp_t e, input int kk);
        int         s;
        int         o;
        logic [3:0] sel;
        logic [3:0] exp_an;
        logic       exp_dp;
        logic       exp_ft;
        s      = kk / TICK_DIV;
        o      = kk % TICK_DIV;
        exp_ft = (kk == 0);
        sel    = 4'b0001 << s;
        if (o < DEAD_CYCLES) begin
            exp_an = 4'b1111;
            exp_dp = 1'b1;
        end else begin
            exp_an = e.shown[s] ? ~sel : 4'b1111;
            exp_dp = (e.shown[s] && e.dpm[s]) ? 1'b0 : 1'b1;
        end
        check($sformatf("ctl_k%0d", kk), {10'd0, frame_tick, an, dp}, {10'd0, exp_ft, exp_an, exp_dp});
        if (o >= DEAD_CYCLES)
            check($sformatf("digit_k%0d", kk), {12'd0, mdigit}, {12'd0, e.dig[s]});
        else if (s > 0)
            check($sformatf("hold_k%0d", kk), {12'd0, mdigit}, {12'd0, e.dig[s-1]});
    endtask

    // Monitor: idle cycles must be dark; FRAME_TICK pops the next expected frame.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
            idle     = 0;
        end else if (in_frame) begin
            check_cycle(cur, k);
            k++;
            if (k == cur.len) begin
                in_frame = 1'b0;
                idle     = 0;
            end
        end else if (frame_tick) begin
            if (exp_q.size() == 0) begin
                check("spurious_tick", {15'd0, frame_tick}, 16'd0);
            end else begin
                cur = exp_q.pop_front();
                if (cur.gap >= 0)
                    check("gap_len", 16'(idle), 16'(cur.gap));
                check_cycle(cur, 0);
                k           = 1;
                in_frame    = (cur.len > 1);
                idle        = 0;
                frames_seen++;
            end
        end else begin
            check("idle_dark", {11'd0, an, dp}, {11'd0, 4'b1111, 1'b1});
            idle++;
            if (exp_q.size() != 0 && idle > 100) begin
                check("tick_timeout", {15'd0, frame_tick}, 16'd1);
                void'(exp_q.pop_front());
                frames_seen++;
                idle = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame's inputs so they are sampled at the next edge, queue the
    // expectation, scramble the inputs after the snapshot, then run len cycles
    // and optionally park the scanner for gap cycles.
    task automatic run_frame(input logic [15:0] dig, input logic [3:0] dpm, input logic [3:0] blm,
                             input logic lz, input int len, input int gap);
        {d3, d2, d1, d0} = dig;
        dp_mask    = dpm;
        blink_mask = blm;
        lzb        = lz;
        enable     = 1'b1;
        exp_q.push_back(build_exp(dig, dpm, blm, lz, n_model, len, prev_gap));
        n_model++;
        pushed++;
        prev_gap = gap;
        tick();
        {d3, d2, d1, d0} = 16'($urandom);
        dp_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
        lzb        = 1'($urandom);
        repeat (len - 1) tick();
        if (gap > 0) begin
            enable = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (frames_seen < pushed || in_frame); i++) tick();
        check("frames_drained", 16'(frames_seen), 16'(pushed));
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        {d3, d2, d1, d0} = 16'h0;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        lzb        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {12'd0, an}, 16'hF);
        check("rst_mdigit", {12'd0, mdigit}, 16'h0);
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_tick", {15'd0, frame_tick}, 16'd0);

        @(negedge clk);
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        // Basic scan, then leading-zero cases
        run_frame(16'h4321, 4'h0, 4'h0, 1'b0, FRAME, 0);
        run_frame(16'h0005, 4'h0, 4'h0, 1'b1, FRAME, 0);
        run_frame(16'h0000, 4'h0, 4'h0, 1'b1, FRAME, 0);
        run_frame(16'h0700, 4'h0, 4'h0, 1'b1, FRAME, 0);
        // Blink on digit 2 and decimal point on digit 1 across three phases
        for (int f = 0; f < 6; f++)
            run_frame(16'h8642, 4'b0010, 4'b0100, 1'b0, FRAME, 0);
        // Enable drop mid-show of slot 2, then drop exactly at frame end
        run_frame(16'h1234, 4'hF, 4'h0, 1'b0, 2 * TICK_DIV + DEAD_CYCLES + 3, 3);
        run_frame(16'h5678, 4'h5, 4'h0, 1'b0, FRAME, 2);
        // Non-BCD nibbles pass through; a nonzero leftmost digit defeats LZB
        run_frame(16'hFA0C, 4'h0, 4'h0, 1'b1, FRAME, 0);

        for (int f = 0; f < 20; f++) begin
            logic [15:0] dig;
            int          len;
            int          gap;
            dig = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, FRAME);
                gap = $urandom_range(1, 4);
            end else begin
                len = FRAME;
                gap = 0;
            end
            run_frame(dig, 4'($urandom), 4'($urandom), 1'($urandom), len, gap);
        end
        enable = 1'b0;
        drain();

        // Asynchronous reset in the middle of a lit slot
        mon_en = 1'b0;
        tick();
        {d3, d2, d1, d0} = 16'h9876;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        lzb        = 1'b0;
        enable     = 1'b1;
        tick();
        check("pre_rst_tick", {15'd0, frame_tick}, 16'd1);
        repeat (4) tick();
        check("pre_rst_an", {12'd0, an}, 16'hE);
        check("pre_rst_digit", {12'd0, mdigit}, 16'h6);
        #2 reset = 1'b0;
        #1;
        check("async_an", {12'd0, an}, 16'hF);
        check("async_dp", {15'd0, dp}, 16'd1);
        check("async_mdigit", {12'd0, mdigit}, 16'h0);
        check("async_tick", {15'd0, frame_tick}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tick", {15'd0, frame_tick}, 16'd1);
        check("post_rst_an", {12'd0, an}, 16'hF);
        repeat (2) tick();
        check("post_rst_show", {12'd0, an}, 16'hE);
        check("post_rst_digit", {12'd0, mdigit}, 16'h6);

        // Blink pacing restarts from reset: the snapshot above was frame 0
        enable = 1'b0;
        tick();
        n_model  = 1;
        prev_gap = -1;
        mon_en   = 1'b1;
        for (int f = 0; f < 4; f++)
            run_frame(16'h1234, 4'h0, 4'b0001, 1'b0, FRAME, 0);
        enable = 1'b0;
        drain();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
